// File: rtl/gerenciador_de_ataque_param.sv
// gerenciador_de_ataque_param
//   Attack manager for the naval-battle game, parametrised on board size and
//   starting lives. Records hits in a COLS x ROWS matrix, drives the status
//   LEDs and life counter, and runs the game state machine that detects
//   victory and defeat. The ship map is frozen when the game starts.
//
//   Optional feature macro: GERENCIADOR_REPETIDO_PENALIZA_EN
//     defined   : attacking an already-hit cell is a miss (LED_R, vida-1)
//     undefined : attacking an already-hit cell is neutral (LED_B only)
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high clear
//   enable       game active; low clears everything like reset
//   confirmar    attack confirm level (rising edge detected internally)
//   coordColuna  attacked column
//   coordLinha   attacked row
//   mapa         ship map, cell (c,l) at bit c*ROWS+l
//   matriz       hit matrix, same indexing as mapa
//   LED_R/G/B    status of the last attack (miss / hit / invalid-neutral)
//   vida         remaining lives
//   acertos      distinct hits so far
//   fim_de_jogo  game over
//   vitoria      game ended in victory
module gerenciador_de_ataque_param #(
  parameter int COLS  = 5,
  parameter int ROWS  = 7,
  parameter int LIVES = 3,
  localparam int N  = COLS * ROWS,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int LW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int VW = $clog2(LIVES + 1),
  localparam int AW = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          confirmar,
  input  logic [CW-1:0] coordColuna,
  input  logic [LW-1:0] coordLinha,
  input  logic [N-1:0]  mapa,
  output logic [N-1:0]  matriz,
  output logic          LED_R,
  output logic          LED_G,
  output logic          LED_B,
  output logic [VW-1:0] vida,
  output logic [AW-1:0] acertos,
  output logic          fim_de_jogo,
  output logic          vitoria
);

  typedef enum logic [1:0] {OCIOSO, JOGANDO, VITORIA, DERROTA} estado_t;

  estado_t       state;
  logic          conf_q;
  logic [N-1:0]  map_q;
  logic [AW-1:0] alvos;

  // Attack request register: the edge and coordinates captured on edge N,
  // applied to the game state on edge N+1.
  logic          atk_vld;
  logic          atk_inval;
  logic [IW-1:0] atk_idx;

  logic          edge_det;
  logic          inval;
  logic [IW-1:0] idx_c;
  logic [AW-1:0] pop;

  assign edge_det = confirmar & ~conf_q & (state == JOGANDO);
  assign inval    = (int'(coordColuna) >= COLS) || (int'(coordLinha) >= ROWS);

  // Index only formed for in-range coordinates so it never aliases a cell.
  always_comb begin
    idx_c = '0;
    if (!inval) idx_c = IW'(int'(coordColuna) * ROWS + int'(coordLinha));
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + AW'(mapa[i]);
  end

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      state       <= OCIOSO;
      conf_q      <= 1'b0;
      map_q       <= '0;
      alvos       <= '0;
      atk_vld     <= 1'b0;
      atk_inval   <= 1'b0;
      atk_idx     <= '0;
      matriz      <= '0;
      LED_R       <= 1'b0;
      LED_G       <= 1'b0;
      LED_B       <= 1'b0;
      vida        <= VW'(LIVES);
      acertos     <= '0;
      fim_de_jogo <= 1'b0;
      vitoria     <= 1'b0;
    end else begin
      conf_q    <= confirmar;
      atk_vld   <= edge_det;
      atk_inval <= inval;
      atk_idx   <= idx_c;
      case (state)
        OCIOSO: begin
          map_q <= mapa;
          alvos <= pop;
          state <= JOGANDO;
        end
        JOGANDO: begin
          // End-of-game checks use the counters updated on the previous edge;
          // victory wins if both conditions hold together.
          if (acertos == alvos) begin
            state       <= VITORIA;
            fim_de_jogo <= 1'b1;
            vitoria     <= 1'b1;
          end else if (vida == '0) begin
            state       <= DERROTA;
            fim_de_jogo <= 1'b1;
          end else if (atk_vld) begin
            if (atk_inval) begin
              {LED_R, LED_G, LED_B} <= 3'b001;
            end else if (map_q[atk_idx] && !matriz[atk_idx]) begin
              matriz[atk_idx]       <= 1'b1;
              acertos               <= acertos + 1'b1;
              {LED_R, LED_G, LED_B} <= 3'b010;
            end else if (!map_q[atk_idx]) begin
              {LED_R, LED_G, LED_B} <= 3'b100;
              if (vida != '0) vida <= vida - 1'b1;
            end else begin
`ifdef GERENCIADOR_REPETIDO_PENALIZA_EN
              {LED_R, LED_G, LED_B} <= 3'b100;
              if (vida != '0) vida <= vida - 1'b1;
`else
              {LED_R, LED_G, LED_B} <= 3'b001;
`endif
            end
          end
        end
        default: ; // VITORIA / DERROTA: everything frozen
      endcase
    end
  end

endmodule

// File: tb/tb_gerenciador_de_ataque_param.sv
module tb_gerenciador_de_ataque_param;

  localparam logic [34:0] MAP = 35'h7_0000_1071;

  logic        clock, reset, enable, confirmar;
  logic [2:0]  coordColuna, coordLinha;
  logic [34:0] mapa, matriz;
  logic        LED_R, LED_G, LED_B;
  logic [1:0]  vida;
  logic [5:0]  acertos;
  logic        fim_de_jogo, vitoria;

  int cmp  = 0;
  int mism = 0;

  gerenciador_de_ataque_param #(.COLS(5), .ROWS(7), .LIVES(3)) dut (
    .clock(clock), .reset(reset), .enable(enable), .confirmar(confirmar),
    .coordColuna(coordColuna), .coordLinha(coordLinha), .mapa(mapa),
    .matriz(matriz), .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B),
    .vida(vida), .acertos(acertos), .fim_de_jogo(fim_de_jogo), .vitoria(vitoria)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [2:0] c, input logic [2:0] l);
    coordColuna = c; coordLinha = l; confirmar = 1; tick();
    confirmar = 0; tick();
  endtask

  task automatic start_game(input logic [34:0] m);
    reset = 1; enable = 1; confirmar = 0; mapa = m; tick();
    reset = 0; tick();
  endtask

  task automatic test_reset();
    reset = 1; enable = 0; confirmar = 0; mapa = MAP; coordColuna = 0; coordLinha = 0;
    tick(); reset = 0; tick();
    cmp++; if (matriz !== 35'h0) begin mism++; $display("FAIL reset_matriz got %h want 0", matriz); end
    cmp++; if (vida !== 2'd3) begin mism++; $display("FAIL reset_vida got %0d want 3", vida); end
    cmp++; if ({LED_R, LED_G, LED_B} !== 3'b000) begin mism++; $display("FAIL reset_leds got %b want 000", {LED_R, LED_G, LED_B}); end
    enable = 1; tick(); tick(); tick();
    cmp++; if (acertos !== 6'd0) begin mism++; $display("FAIL idle_acertos got %0d want 0", acertos); end
    cmp++; if ({fim_de_jogo, vitoria} !== 2'b00) begin mism++; $display("FAIL idle_fim got %b want 00", {fim_de_jogo, vitoria}); end
    cmp++; if (vida !== 2'd3) begin mism++; $display("FAIL idle_vida got %0d want 3", vida); end
  endtask

  task automatic test_hit_hold();
    start_game(MAP);
    coordColuna = 4; coordLinha = 4; confirmar = 1; tick();
    coordColuna = 0; coordLinha = 1;           // a miss, if it were re-attacked
    repeat (5) tick();
    confirmar = 0; tick();
    cmp++; if (matriz !== (35'h1 << 32)) begin mism++; $display("FAIL hold_matriz got %h want %h", matriz, 35'h1 << 32); end
    cmp++; if (acertos !== 6'd1) begin mism++; $display("FAIL hold_acertos got %0d want 1", acertos); end
    cmp++; if (vida !== 2'd3) begin mism++; $display("FAIL hold_vida got %0d want 3", vida); end
    cmp++; if ({LED_R, LED_G, LED_B} !== 3'b010) begin mism++; $display("FAIL hold_leds got %b want 010", {LED_R, LED_G, LED_B}); end
  endtask

  task automatic test_latency();
    start_game(MAP);
    coordColuna = 0; coordLinha = 0; confirmar = 1; tick();
    cmp++; if (acertos !== 6'd0) begin mism++; $display("FAIL lat_early got %0d want 0", acertos); end
    confirmar = 0; tick();
    cmp++; if (matriz !== 35'h1) begin mism++; $display("FAIL lat_matriz got %h want 1", matriz); end
    cmp++; if ({LED_R, LED_G, LED_B} !== 3'b010) begin mism++; $display("FAIL lat_leds got %b want 010", {LED_R, LED_G, LED_B}); end
  endtask

  task automatic test_defeat();
    start_game(MAP);
    pulse(0, 1);
    cmp++; if ({LED_R, LED_G, LED_B} !== 3'b100) begin mism++; $display("FAIL miss_leds got %b want 100", {LED_R, LED_G, LED_B}); end
    cmp++; if (vida !== 2'd2) begin mism++; $display("FAIL miss1_vida got %0d want 2", vida); end
    pulse(0, 1);
    cmp++; if (vida !== 2'd1) begin mism++; $display("FAIL miss2_vida got %0d want 1", vida); end
    pulse(0, 1);
    cmp++; if (vida !== 2'd0) begin mism++; $display("FAIL miss3_vida got %0d want 0", vida); end
    cmp++; if (fim_de_jogo !== 1'b0) begin mism++; $display("FAIL defeat_early got %b want 0", fim_de_jogo); end
    tick();
    cmp++; if ({fim_de_jogo, vitoria} !== 2'b10) begin mism++; $display("FAIL defeat_flags got %b want 10", {fim_de_jogo, vitoria}); end
    pulse(0, 0);
    cmp++; if (matriz !== 35'h0) begin mism++; $display("FAIL defeat_frozen_matriz got %h want 0", matriz); end
    cmp++; if ({LED_R, LED_G, LED_B, vida} !== 5'b10000) begin mism++; $display("FAIL defeat_frozen got %b want 10000", {LED_R, LED_G, LED_B, vida}); end
  endtask

  task automatic test_invalid();
    start_game(MAP);
    pulse(0, 0);
    pulse(5, 0);
    cmp++; if ({LED_R, LED_G, LED_B} !== 3'b001) begin mism++; $display("FAIL inv_col_leds got %b want 001", {LED_R, LED_G, LED_B}); end
    pulse(0, 7);
    cmp++; if ({LED_R, LED_G, LED_B} !== 3'b001) begin mism++; $display("FAIL inv_row_leds got %b want 001", {LED_R, LED_G, LED_B}); end
    pulse(7, 6);
    cmp++; if (matriz !== 35'h1) begin mism++; $display("FAIL inv_matriz got %h want 1", matriz); end
    cmp++; if (vida !== 2'd3) begin mism++; $display("FAIL inv_vida got %0d want 3", vida); end
    cmp++; if (acertos !== 6'd1) begin mism++; $display("FAIL inv_acertos got %0d want 1", acertos); end
  endtask

  task automatic test_repeat();
    start_game(MAP);
    pulse(0, 0);
    pulse(0, 0);
`ifdef GERENCIADOR_REPETIDO_PENALIZA_EN
    cmp++; if ({LED_R, LED_G, LED_B} !== 3'b100) begin mism++; $display("FAIL rep_leds got %b want 100", {LED_R, LED_G, LED_B}); end
    cmp++; if (vida !== 2'd2) begin mism++; $display("FAIL rep_vida got %0d want 2", vida); end
`else
    cmp++; if ({LED_R, LED_G, LED_B} !== 3'b001) begin mism++; $display("FAIL rep_leds got %b want 001", {LED_R, LED_G, LED_B}); end
    cmp++; if (vida !== 2'd3) begin mism++; $display("FAIL rep_vida got %0d want 3", vida); end
`endif
    cmp++; if ({matriz, acertos} !== {35'h1, 6'd1}) begin mism++; $display("FAIL rep_state got %h/%0d want 1/1", matriz, acertos); end
  endtask

  task automatic test_victory();
    start_game(MAP);
    mapa = 35'h0;                      // ignored once the game has started
    pulse(0, 0); pulse(0, 4); pulse(0, 5); pulse(0, 6);
    pulse(1, 5); pulse(4, 4); pulse(4, 5); pulse(4, 6);
    cmp++; if (acertos !== 6'd8) begin mism++; $display("FAIL vic_acertos got %0d want 8", acertos); end
    cmp++; if (matriz !== MAP) begin mism++; $display("FAIL vic_matriz got %h want %h", matriz, MAP); end
    cmp++; if (vida !== 2'd3) begin mism++; $display("FAIL vic_vida got %0d want 3", vida); end
    cmp++; if (fim_de_jogo !== 1'b0) begin mism++; $display("FAIL vic_early got %b want 0", fim_de_jogo); end
    tick();
    cmp++; if ({fim_de_jogo, vitoria} !== 2'b11) begin mism++; $display("FAIL vic_flags got %b want 11", {fim_de_jogo, vitoria}); end
    pulse(0, 1);
    cmp++; if ({LED_R, LED_G, LED_B, vida} !== 5'b01011) begin mism++; $display("FAIL vic_frozen got %b want 01011", {LED_R, LED_G, LED_B, vida}); end
    enable = 0; tick();
    cmp++; if ({matriz, acertos} !== 41'h0) begin mism++; $display("FAIL en0_clear got %h/%0d want 0/0", matriz, acertos); end
    cmp++; if ({LED_R, LED_G, LED_B, vida, fim_de_jogo, vitoria} !== 7'b0001100) begin mism++; $display("FAIL en0_outs got %b want 0001100", {LED_R, LED_G, LED_B, vida, fim_de_jogo, vitoria}); end
    enable = 1;
  endtask

  task automatic test_zero_targets();
    start_game(35'h0);
    cmp++; if (fim_de_jogo !== 1'b0) begin mism++; $display("FAIL zero_entry got %b want 0", fim_de_jogo); end
    tick();
    cmp++; if ({fim_de_jogo, vitoria} !== 2'b11) begin mism++; $display("FAIL zero_flags got %b want 11", {fim_de_jogo, vitoria}); end
  endtask

  task automatic test_entry_edge();
    reset = 1; confirmar = 0; tick();
    reset = 0; enable = 1; mapa = MAP; coordColuna = 0; coordLinha = 0; confirmar = 1;
    tick(); tick(); tick(); tick();
    cmp++; if (acertos !== 6'd0) begin mism++; $display("FAIL entry_held got %0d want 0", acertos); end
    confirmar = 0; tick();
    pulse(0, 0);
    cmp++; if (acertos !== 6'd1) begin mism++; $display("FAIL entry_next got %0d want 1", acertos); end
  endtask

  initial begin
    test_reset();
    test_hit_hold();
    test_latency();
    test_defeat();
    test_invalid();
    test_repeat();
    test_victory();
    test_zero_targets();
    test_entry_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule
